div_ctrl: RTL and testbench

Multi-cycle divider controller for the E stage of the 5-stage MIPS pipeline. It sequences a 32-iteration restoring shift-subtract divide for DIV/DIVU and produces the 64-bit {HI, LO} result. It also generates `div_ready`, which the hazard unit uses to hold F/D/E while a divide is in flight. Operands are captured on start, so the stalled E stage need not keep them stable.

---
 rtl/div_ctrl_pkg.sv | 17 +
 rtl/div_ctrl_if.sv | 23 ++
 rtl/div_ctrl_iter.sv | 27 ++
 rtl/div_ctrl.sv | 98 +++++++++
 tb/tb_div_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider controller (state encodings, width,
// and the DIV/DIVU function codes the top level decodes into start/signed_div).
package div_ctrl_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // MIPS SPECIAL funct codes for DIV and DIVU
  localparam logic [5:0] DIV_CONTROL  = 6'b011010;
  localparam logic [5:0] DIVU_CONTROL = 6'b011011;

endpackage

// File: rtl/div_ctrl_if.sv
// Handshake/operand bundle between the E stage (master) and the divider (slave).
interface div_ctrl_if #(
  parameter int WIDTH = div_ctrl_pkg::DIV_WIDTH
);
  logic                 start;
  logic                 signed_div;
  logic                 annul;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic                 div_ready;
  logic                 busy;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_div, annul, opa, opb,
    input  div_ready, busy, result
  );

  modport slave (
    input  start, signed_div, annul, opa, opb,
    output div_ready, busy, result
  );
endinterface

// File: rtl/div_ctrl_iter.sv
// div_iter: one combinational restoring shift-subtract step on {rem, quo}.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Shifted partial remainder can reach 2*divisor-1, so one extra bit plus a borrow bit.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, divisor_i};

  always_comb begin
    if (!diff[WIDTH+1]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider controller for DIV/DIVU in the E stage.
// Optional DIV_EARLY_OUT_EN: finish immediately when |opa| < |opb|.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  div_ctrl_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  div_state_e          state_q, state_d;
  logic [CW-1:0]       count_q;
  logic [WIDTH-1:0]    rem_q, quo_q, dvs_q;
  logic                neg_quo_q, neg_rem_q;
  logic [2*WIDTH-1:0]  result_q;

  logic [WIDTH-1:0]    opa_mag, opb_mag;
  logic [WIDTH-1:0]    rem_step, quo_step;
  logic                opa_neg, opb_neg;
  logic                take, div_zero, early, last_step;

  assign opa_neg   = bus.signed_div & bus.opa[WIDTH-1];
  assign opb_neg   = bus.signed_div & bus.opb[WIDTH-1];
  assign opa_mag   = opa_neg ? (~bus.opa + 1'b1) : bus.opa;
  assign opb_mag   = opb_neg ? (~bus.opb + 1'b1) : bus.opb;
  assign take      = (state_q == DIV_IDLE) && bus.start && !bus.annul;
  assign div_zero  = (bus.opb == '0);
  assign last_step = (state_q == DIV_BUSY) && (count_q == CW'(WIDTH-1));

`ifdef DIV_EARLY_OUT_EN
  assign early = (opa_mag < opb_mag) && !div_zero;
`else
  assign early = 1'b0;
`endif

  div_iter #(.WIDTH(WIDTH)) u_iter (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_step),
    .quo_o     (quo_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (take) state_d = (div_zero || early) ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (last_step) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (bus.annul) state_d = DIV_IDLE;
  end

  // Outputs depend on registered state only, so the hazard unit sees no input path.
  always_comb begin
    bus.div_ready = (state_q == DIV_DONE);
    bus.busy      = (state_q == DIV_BUSY);
  end

  assign bus.result = result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (take) begin
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= opa_mag;
      dvs_q     <= opb_mag;
      neg_quo_q <= opa_neg ^ opb_neg;
      neg_rem_q <= opa_neg;
      if (div_zero)   result_q <= {bus.opa, {WIDTH{1'b1}}};
      else if (early) result_q <= {bus.opa, {WIDTH{1'b0}}};
    end else if (state_q == DIV_BUSY && !bus.annul) begin
      count_q <= count_q + CW'(1);
      rem_q   <= rem_step;
      quo_q   <= quo_step;
      if (last_step)
        result_q <= {neg_rem_q ? (~rem_step + 1'b1) : rem_step,
                     neg_quo_q ? (~quo_step + 1'b1) : quo_step};
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// Directed scoreboard bench for div_ctrl: latency, busy length, results, annul, reset.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          busy_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_ctrl_if #(.WIDTH(32)) bus ();
  div_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_res = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    exp_t        e;
    longint      la, lb, ma, mb, q, r;
    logic [63:0] qv, rv;
    la = sg ? longint'($signed(a)) : longint'(a);
    lb = sg ? longint'($signed(b)) : longint'(b);
    ma = (la < 0) ? -la : la;
    mb = (lb < 0) ? -lb : lb;
    if (b == 32'd0) begin
      e.res = {a, 32'hFFFF_FFFF}; e.lat = 1; e.busy_n = 0;
      return e;
    end
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) begin
      e.res = {a, 32'h0}; e.lat = 1; e.busy_n = 0;
      return e;
    end
`endif
    q = la / lb;
    r = la % lb;
    qv = q; rv = r;
    e.res = {rv[31:0], qv[31:0]}; e.lat = 33; e.busy_n = 32;
    return e;
  endfunction

  // From a negedge at cycle k, advance until div_ready (bounded), counting busy cycles.
  task automatic wait_ready(inout int k, output int busy_n);
    busy_n = 0;
    while (!bus.div_ready && k < 100) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic finish_op(input string tag, input int k, input int busy_n);
    exp_t e;
    check({tag, "_ready"}, 64'(bus.div_ready), 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, 64'(k), 64'(e.lat));
    check({tag, "_busy"}, 64'(busy_n), 64'(e.busy_n));
    check({tag, "_res"}, bus.result, e.res);
    last_res = e.res;
    $display("op %s: lat=%0d busy=%0d result=0x%h", tag, k, busy_n, bus.result);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sg);
    int k, bn;
    sb.push_back(model(a, b, sg));
    bus.start = 1'b1; bus.signed_div = sg; bus.opa = a; bus.opb = b;
    @(negedge clk);
    k = 1;
    bus.start = 1'b0; bus.signed_div = ~sg; bus.opa = $urandom; bus.opb = $urandom;
    wait_ready(k, bn);
    finish_op(tag, k, bn);
    @(negedge clk);
    check({tag, "_pulse1"}, 64'(bus.div_ready), 64'd0);
    check({tag, "_hold"}, bus.result, last_res);
  endtask

  initial begin
    int   k, bn;
    logic seen;
    exp_t e2;
    rst = 1'b1;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
    bus.opa = '0; bus.opb = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(bus.div_ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", bus.result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu_7_2", 32'd7, 32'd2, 1'b0);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op("div_5_0", 32'd5, 32'd0, 1'b1);
    run_op("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1);
    run_op("divu_5_9", 32'd5, 32'd9, 1'b0);
    run_op("divu_max", 32'hFFFF_FFFF, 32'd1, 1'b0);

    // Annul while count == 10 (cycle N+11)
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opa = 32'd1000; bus.opb = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    check("annul_busy", 64'(bus.busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      if (bus.div_ready) seen = 1'b1;
      @(negedge clk);
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    check("annul_result", bus.result, last_res);
    $display("op annul: busy=%0d result=0x%h", bus.busy, bus.result);

    run_op("divu_100_7", 32'd100, 32'd7, 1'b0);

    // Back-to-back with start held continuously
    sb.push_back(model(32'd9, 32'd4, 1'b0));
    e2 = model(32'd20, 32'd6, 1'b0);
    e2.lat = e2.lat + 34;
    sb.push_back(e2);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opa = 32'd9; bus.opb = 32'd4;
    @(negedge clk);
    k = 1;
    wait_ready(k, bn);
    finish_op("b2b_first", k, bn);
    bus.opa = 32'd20; bus.opb = 32'd6;
    @(negedge clk); k++;
    check("b2b_gap_ready", 64'(bus.div_ready), 64'd0);
    @(negedge clk); k++;
    bus.start = 1'b0;
    wait_ready(k, bn);
    finish_op("b2b_second", k, bn);
    @(negedge clk);
    check("b2b_pulse1", 64'(bus.div_ready), 64'd0);

    for (int i = 0; i < 4; i++)
      run_op($sformatf("rand_u%0d", i), $urandom, $urandom_range(1, 5000), 1'b0);
    for (int i = 0; i < 2; i++)
      run_op($sformatf("rand_s%0d", i), $urandom, $urandom, 1'b1);

    // Reset in the middle of an operation
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opa = 32'd77; bus.opb = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_ready", 64'(bus.div_ready), 64'd0);
    check("midrst_result", bus.result, 64'd0);
    $display("op midreset: busy=%0d result=0x%h", bus.busy, bus.result);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_rst", 32'd7, 32'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
